dcache_writeback_unit: RTL and testbench
========================================

Name: dcache_writeback_unit

Overview:
- Writeback stage directly downstream of the per-line miss handler.
- Accepts a writeback request for a dirty victim line or a probed line, and reads the line row by row from the data array.
- Emits the line as a multi-beat TileLink C-channel message: ReleaseData for voluntary writebacks, ProbeAckData for probes.
- For voluntary writebacks it waits for ReleaseAck on the D channel, then pulses completion back to the miss handler.

Parameters:
- IDX_W, 6, set index width
- TAG_W, 20, tag width
- OFF_BITS, 6, block offset bits; address = {tag, idx, OFF_BITS'b0}
- ADDR_W, 32, physical address width; must equal TAG_W+IDX_W+OFF_BITS
- ROW_W, 64, data row and beat width
- BEATS, 8, rows per line, power of two, at least 2
- WAYS, 4, associativity; way_en is one-hot
- SRC_W, 2, TileLink source id width
- DATA_LAT, 2, fixed data-array read latency in cycles, at least 1

Ports:
- clock in 1 : clock
- reset in 1 : asynchronous, active-low reset
- req_valid in 1 : writeback request valid
- req_ready out 1 : unit can accept a request
- req_tag in TAG_W : victim tag
- req_idx in IDX_W : victim set index
- req_way_en in WAYS : victim way, one-hot
- req_param in 3 : TL shrink/report param
- req_voluntary in 1 : 1 = Release, 0 = ProbeAck
- req_source in SRC_W : TL source id
- resp out 1 : one-cycle completion pulse
- idx_valid out 1 : a writeback is in flight (used for set-conflict blocking)
- idx_bits out IDX_W : set index of the in-flight writeback
- data_req_valid out 1 : data-array read request valid
- data_req_ready in 1 : data array accepts the read
- data_req_idx out IDX_W : set index for the read
- data_req_row out log2(BEATS) : row within the line
- data_req_way_en out WAYS : way to read
- data_resp in ROW_W : read data, valid exactly DATA_LAT cycles after the read fires
- release_valid out 1 : C-channel beat valid
- release_ready in 1 : C-channel accepts the beat
- release_opcode out 3 : 7 = ReleaseData, 5 = ProbeAckData
- release_param out 3 : param latched from req_param
- release_source out SRC_W : source latched from req_source
- release_address out ADDR_W : line address
- release_data out ROW_W : beat data
- grant_valid in 1 : ReleaseAck valid on the D channel
- grant_ready out 1 : unit accepts ReleaseAck

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, all counters and flags cleared. Outputs: req_ready=1, resp=0, idx_valid=0, data_req_valid=0, release_valid=0, grant_ready=0. Reads in flight are discarded; the line buffer contents are don't-care.
- States: IDLE, READ, RELEASE, ACK_WAIT.
- IDLE:
  - req_ready=1.
  - On req_valid: latch tag, idx, way_en, param, voluntary, source; clear read_ctr, resp_ctr, beat_ctr, acked; go to READ.
- READ:
  - data_req_valid = (read_ctr < BEATS); data_req_row = read_ctr. A fire increments read_ctr (width log2(BEATS)+1, no wrap).
  - A DATA_LAT-deep valid shift register tracks fires. When its output is 1, data_resp is written to buffer[resp_ctr] and resp_ctr increments.
  - When resp_ctr reaches BEATS, go to RELEASE. This is the earliest cycle after the last row is captured.
- RELEASE:
  - release_valid=1. release_data=buffer[beat_ctr]. release_address={tag, idx, 0} on every beat. Opcode is fixed for the whole message.
  - A fire increments beat_ctr.
  - On the fire of the last beat (beat_ctr==BEATS-1):
    - if !voluntary: resp=1 that cycle, go to IDLE;
    - if voluntary and acked: resp=1, go to IDLE;
    - otherwise go to ACK_WAIT.
- ACK_WAIT: grant_ready=1. On grant_valid: resp=1, go to IDLE.
- grant_ready is 1 in RELEASE and ACK_WAIT when voluntary=1, otherwise 0. An ack taken during RELEASE sets acked.
  - A stray grant_valid while grant_ready=0 is ignored.
- idx_valid=1 in every state except IDLE; idx_bits always equals the latched idx.
- req_ready=0 outside IDLE. A new request can be accepted no earlier than the cycle after resp.
- Stalls: if data_req_ready is held low, read_ctr holds. release_* outputs stay stable while release_valid=1 and release_ready=0.
- Timing: minimum latency from request to resp, non-voluntary, all readies high = 1 + BEATS + DATA_LAT + BEATS cycles.

Optional Feature:
- Macro WB_EARLY_RELEASE_EN.
- Defined: in READ, release_valid = (beat_ctr < resp_ctr), so beats stream out as soon as they are captured. READ and RELEASE merge; completion rules are unchanged. Minimum non-voluntary latency = 1 + BEATS + DATA_LAT cycles.
- Undefined: release starts only after all BEATS rows are buffered, as described above.

Test Plan:
- Non-voluntary probe (tag=0x12345, idx=0x2A, way_en=4'b0100, param=1, source=2, all readies high) -> 8 reads to rows 0..7 of way 2. Then 8 ProbeAckData beats (opcode 5) at address 0x12345A80 carrying the array data in order. resp pulses on the 8th beat; grant_ready stays 0.
- Voluntary release, ack 5 cycles after the last beat -> opcode 7, ACK_WAIT entered, resp asserted in the cycle grant_valid=1, and req_ready=1 the following cycle.
- Voluntary release with ack accepted during beat 4 -> acked set; resp asserted on the last beat fire; ACK_WAIT never entered.
- Backpressure: data_req_ready toggles 1,0,0,1 and release_ready low for 3 cycles on beat 0 -> no row skipped or duplicated, release_* stable while stalled, data intact.
- Reset asserted mid-RELEASE at beat 3 -> all outputs reach reset values immediately. A fresh request after release is handled correctly, with beats starting at row 0.
- With WB_EARLY_RELEASE_EN defined and all readies high -> first beat valid DATA_LAT+1 cycles after the first read fires; resp on cycle 1+8+2=11 after request acceptance.

Source files
------------

// File: rtl/dcache_writeback_unit.sv
// -----------------------------------------------------------------------------
// dcache_writeback_unit
//
// Purpose:
//   Writeback stage that sits downstream of the per-line miss handler. It takes
//   a writeback request for a dirty victim or a probed line, reads the line
//   from the data array row by row into a local buffer, and emits it as a
//   multi-beat TileLink C-channel message (ReleaseData for voluntary
//   writebacks, ProbeAckData for probes). For voluntary writebacks it also
//   waits for ReleaseAck on the D channel before signalling completion.
//
// Optional feature (macro WB_EARLY_RELEASE_EN):
//   Defined   : beats stream out as soon as each row has been captured, so the
//               read and release phases overlap.
//   Undefined : the release starts only once the whole line is buffered.
//
// Ports:
//   clock, reset          clock and asynchronous active-low reset
//   req_*                 writeback request (valid/ready handshake)
//   resp                  one-cycle completion pulse to the miss handler
//   idx_valid, idx_bits   in-flight set index, used for set-conflict blocking
//   data_req_*, data_resp data-array read port (fixed DATA_LAT read latency)
//   release_*             TileLink C-channel beat output
//   grant_valid/ready     ReleaseAck acceptance on the D channel
// -----------------------------------------------------------------------------
module dcache_writeback_unit #(
    parameter int IDX_W    = 6,
    parameter int TAG_W    = 20,
    parameter int OFF_BITS = 6,
    parameter int ADDR_W   = 32,
    parameter int ROW_W    = 64,
    parameter int BEATS    = 8,
    parameter int WAYS     = 4,
    parameter int SRC_W    = 2,
    parameter int DATA_LAT = 2
) (
    input  logic                     clock,
    input  logic                     reset,

    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [TAG_W-1:0]         req_tag,
    input  logic [IDX_W-1:0]         req_idx,
    input  logic [WAYS-1:0]          req_way_en,
    input  logic [2:0]               req_param,
    input  logic                     req_voluntary,
    input  logic [SRC_W-1:0]         req_source,

    output logic                     resp,
    output logic                     idx_valid,
    output logic [IDX_W-1:0]         idx_bits,

    output logic                     data_req_valid,
    input  logic                     data_req_ready,
    output logic [IDX_W-1:0]         data_req_idx,
    output logic [$clog2(BEATS)-1:0] data_req_row,
    output logic [WAYS-1:0]          data_req_way_en,
    input  logic [ROW_W-1:0]         data_resp,

    output logic                     release_valid,
    input  logic                     release_ready,
    output logic [2:0]               release_opcode,
    output logic [2:0]               release_param,
    output logic [SRC_W-1:0]         release_source,
    output logic [ADDR_W-1:0]        release_address,
    output logic [ROW_W-1:0]         release_data,

    input  logic                     grant_valid,
    output logic                     grant_ready
);

    localparam int ROW_BITS = $clog2(BEATS);
    localparam int CTR_W    = ROW_BITS + 1;
    localparam logic [CTR_W-1:0] BEATS_C = CTR_W'(BEATS);
    localparam logic [CTR_W-1:0] LAST_C  = CTR_W'(BEATS - 1);
    localparam logic [CTR_W-1:0] ONE_C   = CTR_W'(1);

    localparam logic [2:0] OP_RELEASE_DATA   = 3'd7;
    localparam logic [2:0] OP_PROBE_ACK_DATA = 3'd5;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        RELEASE,
        ACK_WAIT
    } state_t;

    state_t state;

    // Counters carry one extra bit so they can reach BEATS without wrapping.
    logic [CTR_W-1:0] read_ctr;
    logic [CTR_W-1:0] resp_ctr;
    logic [CTR_W-1:0] beat_ctr;
    logic             acked;

    // One bit per outstanding array read; the top bit marks data_resp valid.
    logic [DATA_LAT-1:0] read_vld_pipe;
    logic [DATA_LAT-1:0] read_vld_pipe_nxt;

    // Request fields held for the lifetime of the writeback.
    logic [TAG_W-1:0] wb_tag;
    logic [IDX_W-1:0] wb_idx;
    logic [WAYS-1:0]  wb_way_en;
    logic [2:0]       wb_param;
    logic             wb_voluntary;
    logic [SRC_W-1:0] wb_source;

    logic [ROW_W-1:0] line_buf [BEATS];

    logic req_fire;
    logic rd_fire;
    logic capture;
    logic rel_fire;
    logic gnt_fire;
    logic last_beat;

    assign req_ready  = (state == IDLE);
    assign req_fire   = req_valid && req_ready;
    assign idx_valid  = (state != IDLE);
    assign idx_bits   = wb_idx;

    assign data_req_valid  = (state == READ) && (read_ctr < BEATS_C);
    assign data_req_idx    = wb_idx;
    assign data_req_row    = read_ctr[ROW_BITS-1:0];
    assign data_req_way_en = wb_way_en;
    assign rd_fire         = data_req_valid && data_req_ready;
    assign capture         = read_vld_pipe[DATA_LAT-1];

`ifdef WB_EARLY_RELEASE_EN
    // A beat may leave as soon as its row is in the buffer.
    assign release_valid = (state == RELEASE) || ((state == READ) && (beat_ctr < resp_ctr));
`else
    assign release_valid = (state == RELEASE);
`endif
    assign release_opcode  = wb_voluntary ? OP_RELEASE_DATA : OP_PROBE_ACK_DATA;
    assign release_param   = wb_param;
    assign release_source  = wb_source;
    assign release_address = {wb_tag, wb_idx, {OFF_BITS{1'b0}}};
    assign release_data    = line_buf[beat_ctr[ROW_BITS-1:0]];
    assign rel_fire        = release_valid && release_ready;
    assign last_beat       = (beat_ctr == LAST_C);

    assign grant_ready = wb_voluntary && ((state == RELEASE) || (state == ACK_WAIT));
    assign gnt_fire    = grant_valid && grant_ready;

    // An ack arriving in the same cycle as the last beat counts as already acked,
    // otherwise the unit would sit in ACK_WAIT for an ack that never comes.
    assign resp = (rel_fire && last_beat && (!wb_voluntary || acked || gnt_fire))
               || ((state == ACK_WAIT) && gnt_fire);

    always_comb begin
        read_vld_pipe_nxt    = read_vld_pipe << 1;
        read_vld_pipe_nxt[0] = rd_fire;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            read_ctr      <= '0;
            resp_ctr      <= '0;
            beat_ctr      <= '0;
            acked         <= 1'b0;
            read_vld_pipe <= '0;
        end else begin
            read_vld_pipe <= read_vld_pipe_nxt;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        read_ctr <= '0;
                        resp_ctr <= '0;
                        beat_ctr <= '0;
                        acked    <= 1'b0;
                        state    <= READ;
                    end
                end
                READ: begin
                    if (rd_fire) read_ctr <= read_ctr + ONE_C;
                    if (capture) resp_ctr <= resp_ctr + ONE_C;
                    // rel_fire can only be set here when beats stream early.
                    if (rel_fire) beat_ctr <= beat_ctr + ONE_C;
                    if (rel_fire && last_beat) state <= resp ? IDLE : ACK_WAIT;
                    else if (resp_ctr == BEATS_C) state <= RELEASE;
                end
                RELEASE: begin
                    if (rel_fire) beat_ctr <= beat_ctr + ONE_C;
                    if (gnt_fire) acked <= 1'b1;
                    if (rel_fire && last_beat) state <= resp ? IDLE : ACK_WAIT;
                end
                ACK_WAIT: begin
                    if (gnt_fire) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (req_fire) begin
            wb_tag       <= req_tag;
            wb_idx       <= req_idx;
            wb_way_en    <= req_way_en;
            wb_param     <= req_param;
            wb_voluntary <= req_voluntary;
            wb_source    <= req_source;
        end
    end

    always_ff @(posedge clock) begin
        if (capture) line_buf[resp_ctr[ROW_BITS-1:0]] <= data_resp;
    end

endmodule

// File: tb/tb_dcache_writeback_unit.sv
// -----------------------------------------------------------------------------
// tb_dcache_writeback_unit
//
// Bench for dcache_writeback_unit. A transaction-level model tracks how many
// rows were read, captured and released, whether the ack arrived, and derives
// every output expectation from those counts once per cycle. The data array is
// emulated with a fixed-latency responder whose contents are a function of
// (salt, idx, way_en, row), so misordered or duplicated rows show up as data
// errors. Directed scenarios pin latency, address, opcode and data literally.
// -----------------------------------------------------------------------------
module tb_dcache_writeback_unit;

    localparam int BEATS    = 8;
    localparam int DATA_LAT = 2;
`ifdef WB_EARLY_RELEASE_EN
    localparam int EARLY = 1;
`else
    localparam int EARLY = 0;
`endif
    localparam int LAT_PROBE = (EARLY != 0) ? (1 + BEATS + DATA_LAT) : (1 + BEATS + DATA_LAT + BEATS);
    localparam int LAT_ACK4  = (EARLY != 0) ? (LAT_PROBE + 1) : LAT_PROBE;

    logic        clock;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [19:0] req_tag;
    logic [5:0]  req_idx;
    logic [3:0]  req_way_en;
    logic [2:0]  req_param;
    logic        req_voluntary;
    logic [1:0]  req_source;
    logic        resp;
    logic        idx_valid;
    logic [5:0]  idx_bits;
    logic        data_req_valid;
    logic        data_req_ready;
    logic [5:0]  data_req_idx;
    logic [2:0]  data_req_row;
    logic [3:0]  data_req_way_en;
    logic [63:0] data_resp;
    logic        release_valid;
    logic        release_ready;
    logic [2:0]  release_opcode;
    logic [2:0]  release_param;
    logic [1:0]  release_source;
    logic [31:0] release_address;
    logic [63:0] release_data;
    logic        grant_valid;
    logic        grant_ready;

    dcache_writeback_unit dut (
        .clock           (clock),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_tag         (req_tag),
        .req_idx         (req_idx),
        .req_way_en      (req_way_en),
        .req_param       (req_param),
        .req_voluntary   (req_voluntary),
        .req_source      (req_source),
        .resp            (resp),
        .idx_valid       (idx_valid),
        .idx_bits        (idx_bits),
        .data_req_valid  (data_req_valid),
        .data_req_ready  (data_req_ready),
        .data_req_idx    (data_req_idx),
        .data_req_row    (data_req_row),
        .data_req_way_en (data_req_way_en),
        .data_resp       (data_resp),
        .release_valid   (release_valid),
        .release_ready   (release_ready),
        .release_opcode  (release_opcode),
        .release_param   (release_param),
        .release_source  (release_source),
        .release_address (release_address),
        .release_data    (release_data),
        .grant_valid     (grant_valid),
        .grant_ready     (grant_ready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] mem(input logic [31:0] salt, input logic [5:0] ix,
                                        input logic [3:0] w, input int row);
        return {salt, 2'b00, ix, 4'h0, w, 16'(row)};
    endfunction

    // Model state
    int          cyc = 0;
    bit          m_busy = 0;
    bit          m_vol;
    logic [19:0] m_tag;
    logic [5:0]  m_idx;
    logic [3:0]  m_way;
    logic [2:0]  m_param;
    logic [1:0]  m_src;
    logic [31:0] m_salt;
    int          m_reads, m_caps, m_age, m_beats;
    bit          m_acked;
    logic [31:0] next_salt;
    bit          vbuf [16];
    logic [63:0] dbuf [16];
    int          acc_cyc, resp_cyc;

    // Observations recorded for the directed literal checks
    int          rec_nbeats;
    logic [2:0]  rec_opc;
    logic [31:0] rec_addr;
    logic [63:0] rec_beat3, rec_first_data;

    bit          prev_stall;
    logic [63:0] prev_data;
    logic [31:0] prev_addr;

    always @(negedge clock) begin
        bit exp_drv, exp_relv, exp_gr, exp_resp, rd_f, rel_f, g_f, was_busy;
        int slot;
        if (!reset) begin
            m_busy = 0; m_reads = 0; m_caps = 0; m_age = 0; m_beats = 0; m_acked = 0;
            prev_stall = 0;
            for (int i = 0; i < 16; i++) vbuf[i] = 0;
        end else begin
            data_resp = dbuf[cyc % 16];
            exp_drv  = m_busy && (m_reads < BEATS);
            exp_relv = m_busy && (m_beats < BEATS) &&
                       ((EARLY != 0) ? (m_beats < m_caps) : (m_caps == BEATS && m_age >= 1));
            exp_gr   = m_busy && m_vol && (m_caps == BEATS) && (m_age >= 1);
            rd_f     = exp_drv && data_req_ready;
            rel_f    = exp_relv && release_ready;
            g_f      = exp_gr && grant_valid;
            exp_resp = m_busy && ((rel_f && m_beats == BEATS - 1 && (!m_vol || m_acked || g_f)) ||
                                  (m_vol && m_beats == BEATS && g_f));

            chk("req_ready", req_ready, !m_busy);
            chk("idx_valid", idx_valid, m_busy);
            chk("data_req_valid", data_req_valid, exp_drv);
            chk("release_valid", release_valid, exp_relv);
            chk("grant_ready", grant_ready, exp_gr);
            chk("resp", resp, exp_resp);
            if (m_busy) chk("idx_bits", idx_bits, m_idx);
            if (exp_drv) begin
                chk("data_req_idx", data_req_idx, m_idx);
                chk("data_req_row", data_req_row, m_reads);
                chk("data_req_way_en", data_req_way_en, m_way);
            end
            if (exp_relv) begin
                chk("release_opcode", release_opcode, m_vol ? 3'd7 : 3'd5);
                chk("release_param", release_param, m_param);
                chk("release_source", release_source, m_src);
                chk("release_address", release_address, {m_tag, m_idx, 6'b0});
                chk("release_data", release_data, mem(m_salt, m_idx, m_way, m_beats));
            end
            if (prev_stall) begin
                chk("stall_data_stable", release_data, prev_data);
                chk("stall_addr_stable", release_address, prev_addr);
            end
            prev_stall = exp_relv && !release_ready;
            prev_data  = release_data;
            prev_addr  = release_address;

            if (release_valid && release_ready) begin
                if (rec_nbeats == 0) begin
                    rec_addr = release_address;
                    rec_first_data = release_data;
                end
                if (rec_nbeats == 3) rec_beat3 = release_data;
                rec_opc = release_opcode;
                rec_nbeats++;
            end

            was_busy = m_busy;
            if (rd_f) begin
                slot = (cyc + DATA_LAT) % 16;
                vbuf[slot] = 1;
                dbuf[slot] = mem(m_salt, m_idx, m_way, m_reads);
                m_reads++;
            end
            if (m_caps == BEATS) m_age++;
            if (vbuf[cyc % 16]) m_caps++;
            vbuf[cyc % 16] = 0;
            dbuf[cyc % 16] = {$urandom, $urandom};
            if (g_f) m_acked = 1;
            if (rel_f) m_beats++;
            if (exp_resp) begin
                m_busy = 0;
                resp_cyc = cyc;
            end
            if (!was_busy && req_valid) begin
                m_busy = 1; m_vol = req_voluntary; m_tag = req_tag; m_idx = req_idx;
                m_way = req_way_en; m_param = req_param; m_src = req_source; m_salt = next_salt;
                m_reads = 0; m_caps = 0; m_age = 0; m_beats = 0; m_acked = 0;
                acc_cyc = cyc; rec_nbeats = 0;
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    int bp_stall;
    int g_cyc;

    // mode: 0 all ready, 1 ack 5 cycles after last beat, 2 ack from beat 4,
    //       3 backpressure, 4 random, 5 reset at beat 3
    task automatic run_txn(input logic [19:0] t, input logic [5:0] ix, input logic [3:0] w,
                           input logic [2:0] p, input logic v, input logic [1:0] s,
                           input logic [31:0] salt, input int mode);
        int n, drp, since;
        bit done;
        bit [3:0] pat;
        pat = 4'b1001;
        data_req_ready = 1; release_ready = 1; grant_valid = 0;
        n = 0;
        while (m_busy && n < 2000) begin tick(); n++; end
        if (mode == 4) repeat ($urandom_range(0, 2)) tick();
        req_tag = t; req_idx = ix; req_way_en = w; req_param = p;
        req_voluntary = v; req_source = s; next_salt = salt;
        req_valid = 1;
        tick();
        req_valid = 0;
        req_tag = 20'($urandom); req_idx = 6'($urandom); req_param = 3'($urandom);
        n = 0; drp = 0; since = 0; done = 0; bp_stall = 0; g_cyc = -1;
        while (m_busy && !done && n < 3000) begin
            case (mode)
                1: begin
                    if (m_beats == BEATS) since++;
                    if (since == 5 && g_cyc < 0) g_cyc = cyc;
                    grant_valid = (since >= 5);
                end
                2: grant_valid = (m_beats >= 4) && !m_acked;
                3: begin
                    data_req_ready = (m_reads < BEATS) ? pat[drp % 4] : 1'b1;
                    drp++;
                    if (m_beats == 0 && release_valid && bp_stall < 3) begin
                        release_ready = 0;
                        bp_stall++;
                    end else begin
                        release_ready = 1;
                    end
                end
                4: begin
                    data_req_ready = ($urandom_range(0, 3) != 0);
                    release_ready  = ($urandom_range(0, 2) != 0);
                    grant_valid    = ($urandom_range(0, 3) == 0);
                end
                5: begin
                    if (m_beats == 3 && release_valid) begin
                        #1 reset = 0;
                        #1;
                        chk("midrst_req_ready", req_ready, 1);
                        chk("midrst_resp", resp, 0);
                        chk("midrst_idx_valid", idx_valid, 0);
                        chk("midrst_data_req_valid", data_req_valid, 0);
                        chk("midrst_release_valid", release_valid, 0);
                        chk("midrst_grant_ready", grant_ready, 0);
                        tick();
                        tick();
                        reset = 1;
                        done = 1;
                    end
                end
                default: ;
            endcase
            if (!done) begin
                tick();
                n++;
            end
        end
        chk("txn_timeout", m_busy, 0);
        grant_valid = 0; data_req_ready = 1; release_ready = 1;
    endtask

    initial begin
        reset = 0; req_valid = 0; req_tag = 0; req_idx = 0; req_way_en = 0; req_param = 0;
        req_voluntary = 0; req_source = 0; data_req_ready = 1; release_ready = 1;
        grant_valid = 0; data_resp = 0; next_salt = 0;
        for (int i = 0; i < 16; i++) dbuf[i] = 64'h0;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp", resp, 0);
        chk("rst_idx_valid", idx_valid, 0);
        chk("rst_data_req_valid", data_req_valid, 0);
        chk("rst_release_valid", release_valid, 0);
        chk("rst_grant_ready", grant_ready, 0);
        reset = 1;
        tick();

        // Probe, all readies high
        run_txn(20'h12345, 6'h2A, 4'b0100, 3'd1, 1'b0, 2'd2, 32'hDEADBEEF, 0);
        chk("probe_latency", 64'(resp_cyc - acc_cyc), 64'(LAT_PROBE));
        chk("probe_address", rec_addr, 32'h12345A80);
        chk("probe_opcode", rec_opc, 3'd5);
        chk("probe_beat_count", 64'(rec_nbeats), 64'd8);
        chk("probe_beat3_data", rec_beat3, 64'hDEADBEEF_2A04_0003);

        // Voluntary, ack 5 cycles after last beat
        run_txn(20'hABCDE, 6'h05, 4'b0001, 3'd2, 1'b1, 2'd1, $urandom, 1);
        chk("vol_opcode", rec_opc, 3'd7);
        chk("vol_resp_on_grant", 64'(resp_cyc), 64'(g_cyc));
        chk("vol_ackwait_latency", 64'(resp_cyc - acc_cyc), 64'(LAT_PROBE + 5));

        // Voluntary, ack offered from beat 4
        run_txn(20'h0F0F0, 6'h3F, 4'b1000, 3'd0, 1'b1, 2'd3, $urandom, 2);
        chk("early_ack_latency", 64'(resp_cyc - acc_cyc), 64'(LAT_ACK4));

        // Backpressure on both read and release paths
        run_txn(20'h55555, 6'h10, 4'b0010, 3'd4, 1'b0, 2'd0, $urandom, 3);
        chk("bp_release_stalls", 64'(bp_stall), 64'd3);
        chk("bp_beat_count", 64'(rec_nbeats), 64'd8);

        // Reset in the middle of the release, then a fresh request
        run_txn(20'h77777, 6'h01, 4'b0100, 3'd3, 1'b1, 2'd1, $urandom, 5);
        run_txn(20'h00001, 6'h11, 4'b0001, 3'd1, 1'b0, 2'd0, 32'h0BADF00D, 0);
        chk("post_reset_row0", rec_first_data, 64'h0BADF00D_1101_0000);
        chk("post_reset_beats", 64'(rec_nbeats), 64'd8);

        for (int k = 0; k < 30; k++) begin
            run_txn(20'($urandom), 6'($urandom), 4'(1 << $urandom_range(0, 3)), 3'($urandom),
                    1'($urandom), 2'($urandom), $urandom, 4);
        end

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
